parking_lot_occupancy: RTL and testbench

Parametrised occupancy tracker for a multi-gate parking lot. Each gate has an outer and an inner beam sensor. A per-gate state machine decodes complete enter and exit sequences, and a shared saturating counter tracks the number of cars inside against a configurable capacity. The block sits behind the sensor synchronisers and drives the lot's status display and full/empty indicators.

---
 rtl/parking_lot_occupancy_if.sv | 33 +++
 rtl/parking_lot_occupancy.sv | 164 ++++++++++++++++
 tb/tb_parking_lot_occupancy.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/parking_lot_occupancy_if.sv
// Sensor inputs and occupancy/status outputs of the parking lot tracker.
//   master: drives outer/inner beams and clear, observes status
//   slave : the tracker itself
//   outer, inner  per-gate beams (1 = blocked)
//   clear         synchronous counter clear
//   count         occupancy, full/empty decodes
//   enter_pulse, exit_pulse  per-gate completed-event pulses
//   overflow, underflow      clamp indications
interface parking_lot_occupancy_if #(
  parameter int unsigned NUM_GATES = 2,
  parameter int unsigned CW        = 5
);
  logic [NUM_GATES-1:0] outer;
  logic [NUM_GATES-1:0] inner;
  logic                 clear;
  logic [CW-1:0]        count;
  logic                 full;
  logic                 empty;
  logic [NUM_GATES-1:0] enter_pulse;
  logic [NUM_GATES-1:0] exit_pulse;
  logic                 overflow;
  logic                 underflow;

  modport master (
    output outer, inner, clear,
    input  count, full, empty, enter_pulse, exit_pulse, overflow, underflow
  );

  modport slave (
    input  outer, inner, clear,
    output count, full, empty, enter_pulse, exit_pulse, overflow, underflow
  );
endinterface

// File: rtl/parking_lot_occupancy.sv
// Multi-gate parking lot occupancy tracker.
// Each gate decodes complete enter/exit beam sequences with its own FSM;
// a shared saturating counter tracks occupancy against CAPACITY.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-high reset
//   lot    sensor inputs / status outputs (see parking_lot_occupancy_if)
module parking_lot_occupancy #(
  parameter int unsigned NUM_GATES = 2,
  parameter int unsigned CAPACITY  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  parking_lot_occupancy_if.slave  lot
);

  localparam int unsigned CW = $clog2(CAPACITY + 1);
  localparam int unsigned GW = $clog2(NUM_GATES + 1);
  localparam int unsigned SW = CW + $clog2(NUM_GATES) + 2;
  localparam logic signed [SW-1:0] CAP_S = SW'(CAPACITY);

  typedef enum logic [2:0] {
    SYNC = 3'd0,
    IDLE = 3'd1,
    E1   = 3'd2,
    E2   = 3'd3,
    E3   = 3'd4,
    X1   = 3'd5,
    X2   = 3'd6,
    X3   = 3'd7
  } gate_state_t;

  gate_state_t          state_q [NUM_GATES];
  gate_state_t          state_d [NUM_GATES];
  logic [1:0]           sens    [NUM_GATES];
  logic [NUM_GATES-1:0] enter_evt_c;
  logic [NUM_GATES-1:0] exit_evt_c;

  logic [GW-1:0]        e_cnt;
  logic [GW-1:0]        x_cnt;
  logic signed [SW-1:0] next_v;
  logic [CW-1:0]        count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;
  logic [NUM_GATES-1:0] enter_q, exit_q;

  // Per-gate sensor code {outer, inner}
  always_comb begin
    for (int g = 0; g < int'(NUM_GATES); g++) begin
      sens[g] = {lot.outer[g], lot.inner[g]};
    end
  end

  // Gate FSM state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int g = 0; g < int'(NUM_GATES); g++) state_q[g] <= SYNC;
    end else begin
      for (int g = 0; g < int'(NUM_GATES); g++) state_q[g] <= state_d[g];
    end
  end

  // Gate FSM next-state; X states mirror E states with outer/inner swapped
  always_comb begin
    for (int g = 0; g < int'(NUM_GATES); g++) begin
      state_d[g] = state_q[g];
      case (state_q[g])
        SYNC: if (sens[g] == 2'b00) state_d[g] = IDLE;
        IDLE: begin
          if (sens[g] == 2'b10)      state_d[g] = E1;
          else if (sens[g] == 2'b01) state_d[g] = X1;
        end
        E1: begin
          if (sens[g] == 2'b11)      state_d[g] = E2;
          else if (sens[g] != 2'b10) state_d[g] = IDLE;
        end
        E2: begin
          if (sens[g] == 2'b01)      state_d[g] = E3;
          else if (sens[g] == 2'b10) state_d[g] = E1;
          else if (sens[g] == 2'b00) state_d[g] = IDLE;
        end
        E3: begin
          if (sens[g] == 2'b11)      state_d[g] = E2;
          else if (sens[g] != 2'b01) state_d[g] = IDLE;
        end
        X1: begin
          if (sens[g] == 2'b11)      state_d[g] = X2;
          else if (sens[g] != 2'b01) state_d[g] = IDLE;
        end
        X2: begin
          if (sens[g] == 2'b10)      state_d[g] = X3;
          else if (sens[g] == 2'b01) state_d[g] = X1;
          else if (sens[g] == 2'b00) state_d[g] = IDLE;
        end
        X3: begin
          if (sens[g] == 2'b11)      state_d[g] = X2;
          else if (sens[g] != 2'b10) state_d[g] = IDLE;
        end
        default: state_d[g] = SYNC;
      endcase
    end
  end

  // Gate FSM outputs: an event is the final all-clear after the third step
  always_comb begin
    enter_evt_c = '0;
    exit_evt_c  = '0;
    for (int g = 0; g < int'(NUM_GATES); g++) begin
      enter_evt_c[g] = (state_q[g] == E3) && (sens[g] == 2'b00);
      exit_evt_c[g]  = (state_q[g] == X3) && (sens[g] == 2'b00);
    end
  end

  // Saturating occupancy update; equal enters and exits cancel exactly
  always_comb begin
    e_cnt = '0;
    x_cnt = '0;
    for (int g = 0; g < int'(NUM_GATES); g++) begin
      e_cnt = e_cnt + GW'(enter_evt_c[g]);
      x_cnt = x_cnt + GW'(exit_evt_c[g]);
    end
    next_v      = SW'(count_q) + SW'(e_cnt) - SW'(x_cnt);
    count_d     = count_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    if (lot.clear) begin
      count_d = '0;
    end else if (next_v > CAP_S) begin
      count_d    = CW'(CAPACITY);
      overflow_d = 1'b1;
    end else if (next_v[SW-1]) begin
      count_d     = '0;
      underflow_d = 1'b1;
    end else begin
      count_d = CW'(next_v);
    end
  end

  // Counter and pulse registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      enter_q     <= '0;
      exit_q      <= '0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      enter_q     <= enter_evt_c;
      exit_q      <= exit_evt_c;
    end
  end

  assign lot.count       = count_q;
  assign lot.full        = (count_q == CW'(CAPACITY));
  assign lot.empty       = (count_q == '0);
  assign lot.enter_pulse = enter_q;
  assign lot.exit_pulse  = exit_q;
  assign lot.overflow    = overflow_q;
  assign lot.underflow   = underflow_q;

endmodule

// File: tb/tb_parking_lot_occupancy.sv
// Testbench for parking_lot_occupancy: directed scenarios plus randomized
// lock-step gate operations checked against an intent-level occupancy model.
module tb_parking_lot_occupancy;

  localparam int NG  = 2;
  localparam int CAP = 16;
  localparam int CW  = $clog2(CAP + 1);

  // Gate operations (intent, not FSM states)
  localparam int OP_NONE = 0;
  localparam int OP_ENT  = 1;
  localparam int OP_EXT  = 2;
  localparam int OP_ABE  = 3;
  localparam int OP_ABX  = 4;

  logic clk;
  logic reset;

  parking_lot_occupancy_if #(.NUM_GATES(NG), .CW(CW)) lot ();

  parking_lot_occupancy #(.NUM_GATES(NG), .CAPACITY(CAP)) dut (
    .clk   (clk),
    .reset (reset),
    .lot   (lot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;
  int exp_count;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // {outer,inner} for each step of an operation
  function automatic logic [1:0] code_of(input int op, input int step);
    logic [1:0] seq [4];
    case (op)
      OP_ENT:  seq = '{2'b10, 2'b11, 2'b01, 2'b00};
      OP_EXT:  seq = '{2'b01, 2'b11, 2'b10, 2'b00};
      OP_ABE:  seq = '{2'b10, 2'b11, 2'b10, 2'b00};
      OP_ABX:  seq = '{2'b01, 2'b11, 2'b01, 2'b00};
      default: seq = '{2'b00, 2'b00, 2'b00, 2'b00};
    endcase
    return seq[step];
  endfunction

  task automatic drive(input int op0, input int op1, input int step);
    logic [1:0] c0, c1;
    c0 = code_of(op0, step);
    c1 = code_of(op1, step);
    lot.outer = {c1[1], c0[1]};
    lot.inner = {c1[0], c0[0]};
  endtask

  task automatic check_status(input string tag);
    check({tag, ".count"}, int'(lot.count), exp_count);
    check({tag, ".full"},  int'(lot.full),  int'(exp_count == CAP));
    check({tag, ".empty"}, int'(lot.empty), int'(exp_count == 0));
  endtask

  // Run one operation on each gate in lock step; the final all-clear
  // lands on the same edge for both gates.
  task automatic run_ops(input string tag, input int op0, input int op1, input bit clr);
    int ne, nx, nxt, dwell;
    bit exp_ovf, exp_unf;
    for (int st = 0; st < 3; st++) begin
      @(negedge clk);
      drive(op0, op1, st);
      dwell = $urandom_range(1, 2);
      repeat (dwell) begin
        @(posedge clk); #1;
        check({tag, ".mid_pulses"},
              int'({lot.enter_pulse, lot.exit_pulse, lot.overflow, lot.underflow}), 0);
        check({tag, ".mid_count"}, int'(lot.count), exp_count);
      end
    end
    @(negedge clk);
    drive(op0, op1, 3);
    lot.clear = clr;
    ne = int'(op0 == OP_ENT) + int'(op1 == OP_ENT);
    nx = int'(op0 == OP_EXT) + int'(op1 == OP_EXT);
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    if (clr) begin
      exp_count = 0;
    end else if (ne != nx) begin
      nxt = exp_count + ne - nx;
      if (nxt > CAP) begin
        exp_count = CAP;
        exp_ovf   = 1'b1;
      end else if (nxt < 0) begin
        exp_count = 0;
        exp_unf   = 1'b1;
      end else begin
        exp_count = nxt;
      end
    end
    @(posedge clk); #1;
    check({tag, ".enter_pulse"}, int'(lot.enter_pulse),
          int'({op1 == OP_ENT, op0 == OP_ENT}));
    check({tag, ".exit_pulse"}, int'(lot.exit_pulse),
          int'({op1 == OP_EXT, op0 == OP_EXT}));
    check({tag, ".overflow"},  int'(lot.overflow),  int'(exp_ovf));
    check({tag, ".underflow"}, int'(lot.underflow), int'(exp_unf));
    check_status(tag);
    @(negedge clk);
    lot.clear = 1'b0;
    @(posedge clk); #1;
    check({tag, ".post_pulses"},
          int'({lot.enter_pulse, lot.exit_pulse, lot.overflow, lot.underflow}), 0);
    check({tag, ".post_count"}, int'(lot.count), exp_count);
  endtask

  initial begin
    int o0, o1;
    bit clr;
    n_checks  = 0;
    n_fail    = 0;
    exp_count = 0;
    reset     = 1'b1;
    lot.outer = '0;
    lot.inner = '0;
    lot.clear = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst.pulses", int'({lot.enter_pulse, lot.exit_pulse, lot.overflow, lot.underflow}), 0);
    check_status("rst");
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // Directed scenarios
    run_ops("entry0", OP_ENT, OP_NONE, 1'b0);
    run_ops("abort0", OP_ABE, OP_NONE, 1'b0);
    run_ops("exit0",  OP_EXT, OP_NONE, 1'b0);
    for (int i = 0; i < CAP; i++) run_ops("fill", OP_ENT, OP_NONE, 1'b0);
    run_ops("over17", OP_ENT, OP_NONE, 1'b0);
    run_ops("clr",    OP_NONE, OP_NONE, 1'b1);
    run_ops("under1", OP_NONE, OP_EXT, 1'b0);
    for (int i = 0; i < 5; i++) run_ops("to5", OP_ENT, OP_NONE, 1'b0);
    run_ops("simul5", OP_ENT, OP_EXT, 1'b0);
    for (int i = 0; i < 5; i++) run_ops("to15", OP_ENT, OP_ENT, 1'b0);
    run_ops("pair15", OP_ENT, OP_ENT, 1'b0);

    // Reset with gate0 part-way through an entry (held at 11)
    @(negedge clk);
    drive(OP_ENT, OP_NONE, 0);
    @(negedge clk);
    drive(OP_ENT, OP_NONE, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    exp_count = 0;
    check_status("midrst");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    drive(OP_ENT, OP_NONE, 2);
    @(posedge clk); #1;
    check("midrst.01", int'({lot.enter_pulse, lot.exit_pulse}), 0);
    @(negedge clk);
    drive(OP_ENT, OP_NONE, 3);
    @(posedge clk); #1;
    check("midrst.00", int'({lot.enter_pulse, lot.exit_pulse}), 0);
    check_status("midrst.00");
    run_ops("after_rst", OP_ENT, OP_NONE, 1'b0);
    run_ops("clr_entry", OP_ENT, OP_NONE, 1'b1);

    // Randomized lock-step operations
    for (int i = 0; i < 80; i++) begin
      o0  = int'($urandom_range(0, 4));
      o1  = int'($urandom_range(0, 4));
      clr = ($urandom_range(0, 9) == 0);
      run_ops("rand", o0, o1, clr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
